// File: rtl/reg_writeback_queue.sv
// Purpose: merge ALU and memory register writes into an in-order queue that feeds the register file write port, with pending-write forwarding.
// Latency: a write accepted at edge N is driven on enc/addrc/datac from edge N+1 to N+2; the qhit/qdata lookup is combinational.
// Backpressure: the readys come from the registered count only; memory has priority, and ALU is refused when only one slot is left and memory is also valid.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     enc,
    output logic [ADDR_W-1:0]        addrc,
    output logic [DATA_W-1:0]        datac,
    input  logic [ADDR_W-1:0]        qaddr,
    output logic                     qhit,
    output logic [DATA_W-1:0]        qdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              ent_q [DEPTH];
    ent_t              ent_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              enc_q, enc_d;
    logic [ADDR_W-1:0] addrc_q, addrc_d;
    logic [DATA_W-1:0] datac_q, datac_d;
    logic              mem_push, alu_push, pop;
    logic [PW-1:0]     alu_slot;
    logic [PW-1:0]     fwd_idx;

    // Readys look only at the registered count, so a pop in the same cycle does not free a slot until the next cycle.
    always_comb begin
        mem_ready = !reset && (count_q < CW'(DEPTH));
        alu_ready = !reset && ((count_q <= CW'(DEPTH - 2)) ||
                               ((count_q == CW'(DEPTH - 1)) && !mem_valid));
    end

    // Enqueue the memory write first, then the ALU write, and pop the head whenever the queue held something before this edge.
    always_comb begin
        mem_push = mem_valid && mem_ready && (mem_addr != '0);
        alu_push = alu_valid && alu_ready && (alu_addr != '0);
        pop      = (count_q != '0);
        ent_d    = ent_q;
        alu_slot = wr_ptr_q + PW'(mem_push);
        if (mem_push) ent_d[wr_ptr_q] = '{addr: mem_addr, data: mem_data};
        if (alu_push) ent_d[alu_slot] = '{addr: alu_addr, data: alu_data};
        wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        enc_d    = pop;
        addrc_d  = pop ? ent_q[rd_ptr_q].addr : addrc_q;
        datac_d  = pop ? ent_q[rd_ptr_q].data : datac_q;
    end

    // Control and output registers; reset drops every queued entry and the write in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            enc_q    <= 1'b0;
            addrc_q  <= '0;
            datac_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            enc_q    <= enc_d;
            addrc_q  <= addrc_d;
            datac_q  <= datac_d;
        end
    end

    // Storage needs no reset; the pointers and count decide which entries are live.
    always_ff @(posedge clock) begin
        ent_q <= ent_d;
    end

    // Forwarding: the output register has the lowest priority, and a younger queue entry overrides an older match.
    always_comb begin
        qhit    = 1'b0;
        qdata   = '0;
        fwd_idx = '0;
        if (qaddr != '0) begin
            if (enc_q && (addrc_q == qaddr)) begin
                qhit  = 1'b1;
                qdata = datac_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && (ent_q[fwd_idx].addr == qaddr)) begin
                    qhit  = 1'b1;
                    qdata = ent_q[fwd_idx].data;
                end
            end
        end
    end

    assign enc   = enc_q;
    assign addrc = addrc_q;
    assign datac = datac_q;
    assign count = count_q;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Purpose: directed bench for reg_writeback_queue, checked against hand-computed values.
// Latency: inputs change 1 time unit after each rising edge, and outputs are checked 1 time unit after that.
// Backpressure: the producers in the stimulus are written to match the ready pattern expected at each step.
module tb_reg_writeback_queue;
    logic        clock;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_addr, alu_addr, addrc, qaddr;
    logic [31:0] mem_data, alu_data, datac, qdata;
    logic        enc, qhit;
    logic [2:0]  count;

    int n_total = 0;
    int n_pass  = 0;

    logic [4:0]  log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] rf [32];

    reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .enc(enc), .addrc(addrc), .datac(datac),
        .qaddr(qaddr), .qhit(qhit), .qdata(qdata), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model and write-port monitor
    always @(posedge clock) if (enc) rf[addrc] <= datac;
    always @(negedge clock) begin
        if (enc) begin
            log_addr.push_back(addrc);
            log_data.push_back(datac);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 0; alu_valid = 0;
        mem_addr = 0; alu_addr = 0; mem_data = 0; alu_data = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        idle_inputs();
        qaddr = 0;
        reset = 1;
        step(2);
        chk("ready_in_reset_mem", {31'b0, mem_ready}, 0);
        chk("ready_in_reset_alu", {31'b0, alu_ready}, 0);
        reset = 0;
        step(10);
        chk("rst_enc", {31'b0, enc}, 0);
        chk("rst_addrc", {27'b0, addrc}, 0);
        chk("rst_datac", datac, 0);
        chk("rst_count", {29'b0, count}, 0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 1);
        chk("rst_alu_ready", {31'b0, alu_ready}, 1);

        // Single ALU write to r31
        alu_valid = 1; alu_addr = 31; alu_data = 32'hAA; qaddr = 31;
        #1 chk("single_alu_ready", {31'b0, alu_ready}, 1);
        step();
        idle_inputs();
        #1;
        chk("single_count_q", {29'b0, count}, 1);
        chk("single_enc_pre", {31'b0, enc}, 0);
        chk("single_fwd_q_hit", {31'b0, qhit}, 1);
        chk("single_fwd_q_dat", qdata, 32'hAA);
        step();
        chk("single_enc", {31'b0, enc}, 1);
        chk("single_addrc", {27'b0, addrc}, 31);
        chk("single_datac", datac, 32'hAA);
        chk("single_count_out", {29'b0, count}, 0);
        chk("single_fwd_out_hit", {31'b0, qhit}, 1);
        chk("single_fwd_out_dat", qdata, 32'hAA);
        step();
        chk("single_enc_off", {31'b0, enc}, 0);
        chk("single_addrc_hold", {27'b0, addrc}, 31);
        chk("single_datac_hold", datac, 32'hAA);
        chk("single_rf31", rf[31], 32'hAA);
        chk("single_fwd_gone", {31'b0, qhit}, 0);

        // Simultaneous memory/ALU push to the same register
        mem_valid = 1; mem_addr = 5; mem_data = 32'h11;
        alu_valid = 1; alu_addr = 5; alu_data = 32'h22; qaddr = 5;
        step();
        idle_inputs();
        #1;
        chk("dual_count", {29'b0, count}, 2);
        chk("dual_fwd_hit", {31'b0, qhit}, 1);
        chk("dual_fwd_young", qdata, 32'h22);
        step();
        chk("dual_enc1", {31'b0, enc}, 1);
        chk("dual_dat1", datac, 32'h11);
        chk("dual_fwd_queue_over_out", qdata, 32'h22);
        step();
        chk("dual_enc2", {31'b0, enc}, 1);
        chk("dual_dat2", datac, 32'h22);
        chk("dual_count_end", {29'b0, count}, 0);
        step();
        chk("dual_enc_off", {31'b0, enc}, 0);

        // Fill towards capacity: r1..r6 with data 0x101..0x106
        log_addr.delete(); log_data.delete();
        qaddr = 0;
        mem_valid = 1; mem_addr = 1; mem_data = 32'h101;
        alu_valid = 1; alu_addr = 2; alu_data = 32'h102;
        #1 chk("fill_a_alu_ready", {31'b0, alu_ready}, 1);
        step();
        mem_addr = 3; mem_data = 32'h103; alu_addr = 4; alu_data = 32'h104;
        #1 chk("fill_b_count", {29'b0, count}, 2);
        chk("fill_b_alu_ready", {31'b0, alu_ready}, 1);
        step();
        mem_addr = 5; mem_data = 32'h105; alu_addr = 6; alu_data = 32'h106;
        #1 chk("fill_c_count", {29'b0, count}, 3);
        chk("fill_c_mem_ready", {31'b0, mem_ready}, 1);
        chk("fill_c_alu_blocked", {31'b0, alu_ready}, 0);
        step();
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        #1 chk("fill_d_count", {29'b0, count}, 3);
        chk("fill_d_alu_ready", {31'b0, alu_ready}, 1);
        step();
        idle_inputs();
        step(8);
        chk("fill_log_size", log_addr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_addr.size()) begin
                chk($sformatf("fill_addr%0d", i), {27'b0, log_addr[i]}, i + 1);
                chk($sformatf("fill_data%0d", i), log_data[i], 32'h101 + i);
            end
        end
        chk("fill_count_end", {29'b0, count}, 0);

        // Address 0 is acknowledged but dropped
        log_addr.delete(); log_data.delete();
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF; qaddr = 0;
        #1 chk("r0_alu_ready", {31'b0, alu_ready}, 1);
        chk("r0_qhit", {31'b0, qhit}, 0);
        step();
        idle_inputs();
        #1 chk("r0_count", {29'b0, count}, 0);
        step(3);
        chk("r0_no_enc", log_addr.size(), 0);

        // Reset in the middle of operation
        mem_valid = 1; mem_addr = 7;  mem_data = 32'h77;
        alu_valid = 1; alu_addr = 8;  alu_data = 32'h88;
        step();
        mem_addr = 9; mem_data = 32'h99; alu_addr = 10; alu_data = 32'hAAA;
        step();
        idle_inputs();
        #1 chk("mid_count", {29'b0, count}, 3);
        reset = 1;
        #1 chk("mid_rst_mem_ready", {31'b0, mem_ready}, 0);
        chk("mid_rst_alu_ready", {31'b0, alu_ready}, 0);
        step();
        reset = 0;
        log_addr.delete(); log_data.delete();
        qaddr = 8;
        #1 chk("mid_enc", {31'b0, enc}, 0);
        chk("mid_count0", {29'b0, count}, 0);
        chk("mid_qhit", {31'b0, qhit}, 0);
        step(6);
        chk("mid_no_writes", log_addr.size(), 0);
        chk("mid_addrc", {27'b0, addrc}, 0);
        chk("mid_datac", datac, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Bound on total run time
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
